// File: rtl/io_responder_pkg.sv
// Shared constants and types for the memory-mapped serial responder.
// Register word offsets, STATUS bit positions and transmitter FSM states.
package io_responder_pkg;

  localparam logic [1:0] OffTxData  = 2'd0;
  localparam logic [1:0] OffStatus  = 2'd1;
  localparam logic [1:0] OffBaudDiv = 2'd2;
  localparam logic [1:0] OffScratch = 2'd3;

  localparam int unsigned StatusBusyBit  = 0;
  localparam int unsigned StatusFullBit  = 1;
  localparam int unsigned StatusOvfBit   = 2;
  localparam int unsigned StatusCountLsb = 3;
  localparam int unsigned StatusCapBit   = 31;

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Synchronous FIFO with occupancy count; a push on a full FIFO is accepted
// when a pop happens in the same cycle.
module tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           rdata_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, wptr_d;
  logic [PtrW-1:0]  rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rptr_q];

  assign push_ok = push_i && (!full_o || pop_i);
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (push_ok) wptr_d = wptr_q + PtrW'(1);
    if (pop_ok)  rptr_d = rptr_q + PtrW'(1);
    if (push_ok && !pop_ok)      count_d = count_q + CntW'(1);
    else if (!push_ok && pop_ok) count_d = count_q - CntW'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/io_responder.sv
// Bus-mapped responder: register decode, TX FIFO, baud divider and serial transmitter.
// Define IO_RESPONDER_PARITY_EN to add an even parity bit to each frame.
module io_responder
  import io_responder_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned DEFAULT_DIV = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        cs,
  input  logic        wr_rd,
  input  logic [31:0] data_bus_write,
  output logic [31:0] data_bus_read,
  output logic        tx
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
`ifdef IO_RESPONDER_PARITY_EN
  localparam logic CapFlag = 1'b1;
`else
  localparam logic CapFlag = 1'b0;
`endif

  logic [1:0]      sel;
  logic            wr_en, push, pop;
  logic            fifo_full, fifo_empty;
  logic [7:0]      fifo_rdata;
  logic [CntW-1:0] fifo_count;
  logic [31:0]     count_ext, status;
  logic            unused_addr;

  logic        ovf_q, ovf_d;
  logic [15:0] baud_div_q, baud_div_d;
  logic [31:0] scratch_q, scratch_d;
  tx_state_e   state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d, div_m1;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
`ifdef IO_RESPONDER_PARITY_EN
  logic        parity_q, parity_d;
`endif

  assign sel         = addr[3:2];
  assign wr_en       = cs && wr_rd;
  assign push        = wr_en && (sel == OffTxData);
  assign unused_addr = ^{addr[31:4], addr[1:0]};
  assign div_m1      = (baud_div_q == '0) ? '0 : baud_div_q - 16'd1;

  tx_fifo #(
    .Depth(FIFO_DEPTH),
    .Width(8)
  ) u_tx_fifo (
    .clk_i  (clk),
    .rst_ni (rst),
    .push_i (push),
    .wdata_i(data_bus_write[7:0]),
    .pop_i  (pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty),
    .count_o(fifo_count)
  );

  always_comb begin
    ovf_d      = ovf_q;
    baud_div_d = baud_div_q;
    scratch_d  = scratch_q;
    if (push && fifo_full && !pop) ovf_d = 1'b1;
    if (wr_en) begin
      unique case (sel)
        OffStatus:  if (data_bus_write[StatusOvfBit]) ovf_d = 1'b0;
        OffBaudDiv: baud_div_d = data_bus_write[15:0];
        OffScratch: scratch_d = data_bus_write;
        default:    ;
      endcase
    end
  end

  // Every bit boundary reloads the counter, so divider changes land there.
  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    pop        = 1'b0;
`ifdef IO_RESPONDER_PARITY_EN
    parity_d   = parity_q;
`endif
    if (state_q == StIdle) begin
      if (!fifo_empty) begin
        pop        = 1'b1;
        shift_d    = fifo_rdata;
        state_d    = StStart;
        baud_cnt_d = div_m1;
`ifdef IO_RESPONDER_PARITY_EN
        parity_d   = ^fifo_rdata;
`endif
      end
    end else if (baud_cnt_q != '0) begin
      baud_cnt_d = baud_cnt_q - 16'd1;
    end else begin
      baud_cnt_d = div_m1;
      unique case (state_q)
        StStart: begin
          state_d   = StData;
          bit_idx_d = '0;
        end
        StData: begin
          shift_d   = shift_q >> 1;
          bit_idx_d = bit_idx_q + 3'd1;
`ifdef IO_RESPONDER_PARITY_EN
          if (bit_idx_q == 3'd7) state_d = StParity;
`else
          if (bit_idx_q == 3'd7) state_d = StStop;
`endif
        end
`ifdef IO_RESPONDER_PARITY_EN
        StParity: state_d = StStop;
`endif
        StStop: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_rdata;
            state_d = StStart;
`ifdef IO_RESPONDER_PARITY_EN
            parity_d = ^fifo_rdata;
`endif
          end else begin
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ovf_q      <= 1'b0;
      baud_div_q <= 16'(DEFAULT_DIV);
      scratch_q  <= '0;
      state_q    <= StIdle;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
`ifdef IO_RESPONDER_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      ovf_q      <= ovf_d;
      baud_div_q <= baud_div_d;
      scratch_q  <= scratch_d;
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
`ifdef IO_RESPONDER_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      StStart:  tx = 1'b0;
      StData:   tx = shift_q[0];
`ifdef IO_RESPONDER_PARITY_EN
      StParity: tx = parity_q;
`endif
      default:  tx = 1'b1;
    endcase
  end

  assign count_ext = 32'(fifo_count);

  always_comb begin
    status                           = '0;
    status[StatusCapBit]             = CapFlag;
    status[StatusCountLsb +: 3]      = count_ext[2:0];
    status[StatusOvfBit]             = ovf_q;
    status[StatusFullBit]            = fifo_full;
    status[StatusBusyBit]            = (state_q != StIdle);
  end

  always_comb begin
    data_bus_read = '0;
    if (cs) begin
      unique case (sel)
        OffTxData:  data_bus_read = '0;
        OffStatus:  data_bus_read = status;
        OffBaudDiv: data_bus_read = {16'b0, baud_div_q};
        OffScratch: data_bus_read = scratch_q;
        default:    data_bus_read = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_io_responder.sv
// Directed bench for io_responder: register access, framing, FIFO overflow and reset abort.
module tb_io_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        cs;
  logic        wr_rd;
  logic [31:0] data_bus_write;
  logic [31:0] data_bus_read;
  logic        tx;

  int n_vec = 0;
  int n_err = 0;

`ifdef IO_RESPONDER_PARITY_EN
  localparam logic [31:0] Cap = 32'h8000_0000;
`else
  localparam logic [31:0] Cap = 32'h0000_0000;
`endif

  always #5 clk = ~clk;

  io_responder #(
    .FIFO_DEPTH (4),
    .DEFAULT_DIV(16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .addr          (addr),
    .cs            (cs),
    .wr_rd         (wr_rd),
    .data_bus_write(data_bus_write),
    .data_bus_read (data_bus_read),
    .tx            (tx)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b1; addr = a; data_bus_write = d;
    @(posedge clk);
    #1;
    cs = 1'b0; wr_rd = 1'b0;
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b0; addr = a;
    #1;
    d = data_bus_read;
    @(posedge clk);
    #1;
    cs = 1'b0;
  endtask

  // Expects the next negedge to fall in the first START cycle.
  task automatic check_frame(input logic [7:0] b, input int div, input bit chk_busy);
    logic [10:0] seq;
    int nb;
    int d;
`ifdef IO_RESPONDER_PARITY_EN
    seq = {1'b0, 1'b1, ^b, b, 1'b0};
    nb  = 11;
`else
    seq = {2'b00, 1'b1, b, 1'b0};
    nb  = 10;
`endif
    d = (div < 1) ? 1 : div;
    for (int i = 0; i < nb; i++) begin
      for (int c = 0; c < d; c++) begin
        @(negedge clk);
        if (chk_busy) begin
          cs = 1'b1; wr_rd = 1'b0; addr = 32'h4;
        end
        #1;
        check($sformatf("tx_%02h_bit%0d_cyc%0d", b, i, c), {31'b0, tx}, {31'b0, seq[i]});
        if (chk_busy) check($sformatf("busy_%02h_bit%0d", b, i), {31'b0, data_bus_read[0]}, 32'd1);
      end
    end
    if (chk_busy) cs = 1'b0;
  endtask

  logic [31:0] r;
  logic [7:0]  bytes [5];
  logic        done;
  logic        saw_low;

  initial begin
    rst = 1'b0; cs = 1'b0; wr_rd = 1'b0; addr = '0; data_bus_write = '0;
    bytes = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Reset state
    #1 check("rst_tx", {31'b0, tx}, 32'd1);
    bus_read(32'h4, r);  check("rst_status", r, Cap);
    bus_read(32'h8, r);  check("rst_bauddiv", r, 32'd16);
    bus_read(32'hC, r);  check("rst_scratch", r, 32'd0);
    bus_read(32'h0, r);  check("txdata_read", r, 32'd0);

    // 0xA5 at DIV=4, busy throughout
    bus_write(32'h8, 32'd4);
    bus_read(32'h8, r);  check("bauddiv_4", r, 32'd4);
    bus_write(32'h0, 32'hA5);
    @(negedge clk); #1 check("a5_prestart_idle", {31'b0, tx}, 32'd1);
    check_frame(8'hA5, 4, 1'b1);
    bus_read(32'h4, r);  check("a5_done_status", r, Cap);

    // Five back-to-back frames at DIV=2
    bus_write(32'h8, 32'd2);
    bus_write(32'h0, {24'b0, bytes[0]});
    fork
      begin
        for (int i = 1; i < 5; i++) bus_write(32'h0, {24'b0, bytes[i]});
      end
      begin
        @(negedge clk); #1 check("b2b_prestart_idle", {31'b0, tx}, 32'd1);
        for (int i = 0; i < 5; i++) check_frame(bytes[i], 2, 1'b0);
      end
    join
    bus_read(32'h4, r);  check("b2b_done_status", r, Cap);

    // Six pushes overflow; W1C clears ovf only
    bus_write(32'h0, 32'h61);
    for (int i = 0; i < 5; i++) bus_write(32'h0, 32'h62 + i);
    bus_read(32'h4, r);  check("ovf_status", r, Cap | 32'h27);
    bus_write(32'h4, 32'h4);
    bus_read(32'h4, r);  check("ovf_cleared", r, Cap | 32'h23);
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      bus_read(32'h4, r);
      if (r == Cap) done = 1'b1;
    end
    check("drain_timeout", {31'b0, done}, 32'd1);

    // BAUDDIV=0 behaves as one cycle per bit
    bus_write(32'h8, 32'd0);
    bus_read(32'h8, r);  check("bauddiv_0", r, 32'd0);
    bus_write(32'h0, 32'h3C);
    @(negedge clk); #1 check("div0_prestart_idle", {31'b0, tx}, 32'd1);
    check_frame(8'h3C, 1, 1'b1);
    bus_read(32'h4, r);  check("div0_done_status", r, Cap);

    // SCRATCH, read-during-write, cs=0
    bus_write(32'hC, 32'hDEADBEEF);
    bus_read(32'hC, r);  check("scratch_rw", r, 32'hDEADBEEF);
    @(negedge clk);
    cs = 1'b1; wr_rd = 1'b1; addr = 32'hC; data_bus_write = 32'h1234_5678;
    #1 check("scratch_pre_edge", data_bus_read, 32'hDEADBEEF);
    @(posedge clk); #1 cs = 1'b0; wr_rd = 1'b0;
    bus_read(32'hC, r);  check("scratch_post_edge", r, 32'h1234_5678);
    @(negedge clk); cs = 1'b0; addr = 32'hC;
    #1 check("cs0_read_zero", data_bus_read, 32'd0);

    // 0x07 frame length (parity bit of 1 when enabled)
    bus_write(32'h8, 32'd3);
    bus_write(32'h0, 32'h07);
    @(negedge clk); #1 check("p07_prestart_idle", {31'b0, tx}, 32'd1);
    check_frame(8'h07, 3, 1'b0);
    bus_read(32'h4, r);  check("p07_done_status", r, Cap);

    // Reset mid-frame with two bytes queued
    bus_write(32'h8, 32'd4);
    bus_write(32'h0, 32'hF0);
    bus_write(32'h0, 32'h0F);
    bus_write(32'h0, 32'hAA);
    repeat (8) @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1 check("rst_mid_tx", {31'b0, tx}, 32'd1);
    @(negedge clk); rst = 1'b1;
    bus_read(32'h4, r);  check("rst_mid_status", r, Cap);
    bus_read(32'h8, r);  check("rst_mid_bauddiv", r, 32'd16);
    saw_low = 1'b0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) saw_low = 1'b1;
    end
    check("rst_mid_quiet", {31'b0, saw_low}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
